// File: rtl/fsmc_reg_bank.sv
// rtl/fsmc_reg_bank.sv - FSMC slave register bank sampled on FPGA_CLK2
// Six R/W registers, a status input and a write counter behind a synchronised FSMC port.
module fsmc_reg_bank #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] RST_VAL     = 16'h0000
) (
  input  logic        FPGA_CLK2,
  input  logic        FPGA_RST_N,
  input  logic [2:0]  AB,
  inout  wire  [15:0] DB,
  input  logic        CS0,
  input  logic        RD,
  input  logic        WR,
  input  logic [15:0] STATUS_IN,
  output logic [95:0] REGS,
  output logic        WR_STB,
  output logic [2:0]  WR_ADDR,
  output logic        RD_STB,
  output logic [2:0]  RD_ADDR
);

  logic [SYNC_STAGES-1:0] cs_sync, rd_sync, wr_sync;
  logic [2:0]             ab_sync [SYNC_STAGES];
  logic [15:0]            db_sync [SYNC_STAGES];

  logic        cs_s, rd_s, wr_s;
  logic [2:0]  ab_s;
  logic [15:0] db_s;

  logic        cs_prev, rd_prev, wr_prev;
  logic [2:0]  ab_prev;
  logic [2:0]  cap_addr;
  logic [15:0] cap_data;
  logic        cap_vld;
  logic [5:0][15:0] regs;
  logic [15:0] wr_cnt;
  logic [15:0] rd_hold;
  logic [15:0] rd_mux;
  logic        wr_rise, rd_rise, db_oe;

  // Strobe histories preset high so reset release never looks like an edge.
  always_ff @(posedge FPGA_CLK2 or negedge FPGA_RST_N) begin
    if (!FPGA_RST_N) begin
      cs_sync <= '1;
      rd_sync <= '1;
      wr_sync <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        ab_sync[i] <= '0;
        db_sync[i] <= '0;
      end
    end else begin
      cs_sync    <= {cs_sync[SYNC_STAGES-2:0], CS0};
      rd_sync    <= {rd_sync[SYNC_STAGES-2:0], RD};
      wr_sync    <= {wr_sync[SYNC_STAGES-2:0], WR};
      ab_sync[0] <= AB;
      db_sync[0] <= DB;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        ab_sync[i] <= ab_sync[i-1];
        db_sync[i] <= db_sync[i-1];
      end
    end
  end

  assign cs_s = cs_sync[SYNC_STAGES-1];
  assign rd_s = rd_sync[SYNC_STAGES-1];
  assign wr_s = wr_sync[SYNC_STAGES-1];
  assign ab_s = ab_sync[SYNC_STAGES-1];
  assign db_s = db_sync[SYNC_STAGES-1];

  assign wr_rise = !wr_prev && wr_s;
  assign rd_rise = !rd_prev && rd_s;

  always_comb begin
    rd_mux = wr_cnt;
    if (ab_s == 3'd6) rd_mux = STATUS_IN;
    for (int i = 0; i < 6; i++) begin
      if (ab_s == 3'(i)) rd_mux = regs[i];
    end
  end

  always_ff @(posedge FPGA_CLK2 or negedge FPGA_RST_N) begin
    if (!FPGA_RST_N) begin
      cs_prev  <= 1'b1;
      rd_prev  <= 1'b1;
      wr_prev  <= 1'b1;
      ab_prev  <= '0;
      cap_addr <= '0;
      cap_data <= '0;
      cap_vld  <= 1'b0;
      regs     <= {6{RST_VAL}};
      wr_cnt   <= '0;
      rd_hold  <= '0;
      WR_STB   <= 1'b0;
      WR_ADDR  <= '0;
      RD_STB   <= 1'b0;
      RD_ADDR  <= '0;
    end else begin
      cs_prev <= cs_s;
      rd_prev <= rd_s;
      wr_prev <= wr_s;
      ab_prev <= ab_s;
      WR_STB  <= 1'b0;
      RD_STB  <= rd_rise && !cs_prev;
      if (rd_rise && !cs_prev) RD_ADDR <= ab_prev;

      // cap_vld ties a WR rising edge to a capture made inside the same access.
      if (!cs_s && !wr_s) begin
        cap_addr <= ab_s;
        cap_data <= db_s;
        cap_vld  <= 1'b1;
      end else if (wr_rise) begin
        cap_vld <= 1'b0;
        if (cap_vld && cap_addr < 3'd6) begin
          for (int i = 0; i < 6; i++) begin
            if (cap_addr == 3'(i)) regs[i] <= cap_data;
          end
          wr_cnt  <= wr_cnt + 16'd1;
          WR_STB  <= 1'b1;
          WR_ADDR <= cap_addr;
        end
      end

      if (rd_s) rd_hold <= rd_mux;
    end
  end

  // Output enable uses the raw pins so the bus turns around without sync delay.
  assign db_oe = FPGA_RST_N && !CS0 && !RD && WR;
  assign DB    = db_oe ? rd_hold : 16'hzzzz;
  assign REGS  = regs;

endmodule

// File: doc/fsmc_reg_bank.md
Name: fsmc_reg_bank

Overview:
- Synchronous FSMC slave register bank. It sits directly downstream of the STM32 FSMC pins and replaces strobe-edge-clocked capture with logic sampled on FPGA_CLK2.
- Provides 6 read/write control registers, 1 read-only status input and 1 read-only write counter.
- Outputs feed LED/PWM and other consumer blocks through a flattened register bus plus a one-cycle write pulse.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers on CS0/RD/WR/AB/DB (minimum 2).
- RST_VAL, 16'h0000, reset value of registers 0-5.

Ports:
- FPGA_CLK2  input  1  system clock, all logic on rising edge.
- FPGA_RST_N  input  1  asynchronous active-low reset.
- AB  input  3  FSMC address, selects register 0-7.
- DB  inout  16  FSMC data bus.
- CS0  input  1  FSMC chip select, active low.
- RD  input  1  FSMC read strobe (NOE), active low.
- WR  input  1  FSMC write strobe (NWE), active low.
- STATUS_IN  input  16  value returned when address 6 is read.
- REGS  output  96  registers 0-5 flattened; reg n occupies bits [16n+15:16n].
- WR_STB  output  1  one-cycle pulse when a register 0-5 is written.
- WR_ADDR  output  3  address of the last committed write.
- RD_STB  output  1  one-cycle pulse at the end of any read access.
- RD_ADDR  output  3  address of the last completed read.

Behaviour:
- Reset (async assert, sync release):
  - REGS = {6{RST_VAL}}; write counter = 0.
  - WR_STB = RD_STB = 0; WR_ADDR = RD_ADDR = 0.
  - Synchroniser and edge-detect history for CS0/RD/WR preset to 1 (inactive), so no spurious strobe after reset.
  - DB is released during reset.
- Synchronisation: CS0, RD, WR, AB and DB each pass through SYNC_STAGES flops. The synced signals are cs_s, rd_s, wr_s, ab_s and db_s.
- Write capture: every cycle with cs_s==0 and wr_s==0, latch ab_s into cap_addr and db_s into cap_data.
- Write commit:
  - Triggered on the wr_s rising edge (previous 0, current 1).
  - cap_addr 0-5: reg[cap_addr] <= cap_data, write counter +1 (16-bit, wraps FFFF->0000), WR_STB=1 for exactly one cycle, WR_ADDR=cap_addr.
  - cap_addr 6 or 7: ignored. No register change, no counter increment, no WR_STB.
  - Commit latency: SYNC_STAGES+1 clocks after the WR pin rises.
- Edge qualification: a WR rising edge with no qualifying capture in the same access (cs_s high throughout) commits nothing.
- Read data:
  - rd_hold loads mux(ab_s) every cycle while rd_s==1.
  - Mux map: 0-5 -> reg, 6 -> STATUS_IN, 7 -> write counter.
  - rd_hold is frozen while rd_s==0.
- DB drive: DB = rd_hold when raw CS0==0 && RD==0 && WR==1, else 16'bz. This enable is combinational on the raw pins so bus turnaround is immediate.
- Read complete: on the rd_s rising edge with cs_s==0 in the previous cycle, RD_STB=1 for one cycle and RD_ADDR=ab_s from the previous cycle.
- Simultaneous events:
  - RD and WR both low: DB is not driven; the write path behaves normally.
  - Commit and read of the same register in adjacent accesses: the read returns the committed value if the read address setup began after the commit cycle.
  - WR_STB and RD_STB may assert in the same cycle.
- Bus timing requirements on firmware (FSMC config):
  - ADDSET ≥ SYNC_STAGES+1 clocks.
  - DATAST ≥ SYNC_STAGES+2 clocks.
  - Strobe-high gap between accesses ≥ 2 clocks.
  - Shorter pulses are out of spec and may be missed.
- Reset mid-access: all state clears immediately and DB is released. The access in progress is discarded with no strobe.

Test Plan:
- Reset with FPGA_RST_N=0, then release; drive CS0/RD/WR=1 -> REGS all 0, WR_STB/RD_STB never pulse, DB is Z.
- Write 16'hE000 to address 0 with a 4-clock WR pulse -> reg0=E000 and one WR_STB pulse with WR_ADDR=0, SYNC_STAGES+1 clocks after WR rises; then read address 7 -> DB=0001.
- Write 16'h1234 to address 6 -> no WR_STB, counter unchanged; read address 6 with STATUS_IN=ABCD -> DB=ABCD and RD_STB with RD_ADDR=6.
- Preload the counter via 65535 writes to address 3, then one more write -> counter reads 0000; reg3 holds the last value.
- Hold RD and WR low together with CS0=0 -> DB stays Z while WR is low; the write commits on WR rise.
- Assert FPGA_RST_N=0 mid-read with DB driven -> DB goes Z asynchronously; no RD_STB after release; REGS=0.
